// File: rtl/rv_hart_sched_if.sv
// Command and issue bundle between the execute/fetch stages and the hart scheduler.
// master drives stall and hart commands and observes the issue; slave is the scheduler.
interface rv_hart_sched_if #(
  parameter int NHARTS = 4,
  parameter int TIDW   = 2
);
  logic              pipe_stall;
  logic              start_valid;
  logic [TIDW-1:0]   start_tid;
  logic              halt_valid;
  logic [TIDW-1:0]   halt_tid;
  logic              wait_valid;
  logic [TIDW-1:0]   wait_tid;
  logic [3:0]        wait_cycles;
  logic              issue_valid;
  logic [TIDW-1:0]   issue_tid;
  logic [NHARTS-1:0] run_mask;

  modport master (
    output pipe_stall, start_valid, start_tid, halt_valid, halt_tid,
           wait_valid, wait_tid, wait_cycles,
    input  issue_valid, issue_tid, run_mask
  );

  modport slave (
    input  pipe_stall, start_valid, start_tid, halt_valid, halt_tid,
           wait_valid, wait_tid, wait_cycles,
    output issue_valid, issue_tid, run_mask
  );
endinterface

// File: rtl/rv_hart_sched.sv
// Round-robin barrel-thread issue scheduler with a per-hart minimum re-issue gap
// and run/idle/wait tracking driven by execute-stage commands.
module rv_hart_sched #(
  parameter int NHARTS  = 4,
  parameter int TIDW    = 2,
  parameter int MIN_GAP = 4
) (
  input  logic           clk,
  input  logic           rst,
  rv_hart_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } hstate_e;

  localparam logic [2:0]      GAP_LD   = 3'(MIN_GAP - 1);
  localparam logic [TIDW-1:0] LAST_RST = TIDW'(NHARTS - 1);

  hstate_e           state_r [NHARTS];
  hstate_e           state_s [NHARTS];
  logic [2:0]        cool_r  [NHARTS];
  logic [2:0]        cool_s  [NHARTS];
  logic [3:0]        wcnt_r  [NHARTS];
  logic [3:0]        wcnt_s  [NHARTS];
  logic [TIDW-1:0]   last_r;
  logic              issue_valid_r;
  logic [TIDW-1:0]   issue_tid_r;
  logic [NHARTS-1:0] run_mask_r;
  logic [NHARTS-1:0] run_mask_s;
  logic              found_s;
  logic [TIDW-1:0]   grant_s;
  logic [3:0]        wait_ld_s;

  // Round-robin search starting just after the last issued hart; the last offset wraps back to it.
  always_comb begin
    logic [TIDW-1:0] idx_v;
    found_s = 1'b0;
    grant_s = last_r;
    idx_v   = last_r;
    for (int k = 1; k <= NHARTS; k++) begin
      idx_v = last_r + TIDW'(k);
      if (!found_s && (state_r[idx_v] == RUN) && (cool_r[idx_v] == 3'd0)) begin
        found_s = 1'b1;
        grant_s = idx_v;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Per-hart next state, wait counter and cooldown.
  always_comb begin
    wait_ld_s  = (bus.wait_cycles == 4'd0) ? 4'd1 : bus.wait_cycles;
    run_mask_s = {NHARTS{1'b0}};
    for (int i = 0; i < NHARTS; i++) begin
      logic halt_v;
      logic wait_v;
      logic start_v;
      halt_v     = bus.halt_valid  && (bus.halt_tid  == TIDW'(i));
      wait_v     = bus.wait_valid  && (bus.wait_tid  == TIDW'(i));
      start_v    = bus.start_valid && (bus.start_tid == TIDW'(i));
      state_s[i] = state_r[i];
      wcnt_s[i]  = wcnt_r[i];
      cool_s[i]  = cool_r[i];

      // Cooldowns model in-flight instructions, so they only advance when the pipe moves.
      if (bus.pipe_stall) begin
        cool_s[i] = cool_r[i];
      end else if (found_s && (grant_s == TIDW'(i))) begin
        cool_s[i] = GAP_LD;
      end else if (cool_r[i] != 3'd0) begin
        cool_s[i] = cool_r[i] - 3'd1;
      end else begin
        cool_s[i] = 3'd0;
      end

      if (halt_v) begin
        state_s[i] = IDLE;
        wcnt_s[i]  = 4'd0;
      end else if (wait_v && (state_r[i] != IDLE)) begin
        state_s[i] = WAIT;
        wcnt_s[i]  = wait_ld_s;
      end else if (start_v) begin
        state_s[i] = RUN;
        wcnt_s[i]  = 4'd0;
      end else begin
        case (state_r[i])
          WAIT: begin
            if (wcnt_r[i] <= 4'd1) begin
              state_s[i] = RUN;
              wcnt_s[i]  = 4'd0;
            end else begin
              wcnt_s[i]  = wcnt_r[i] - 4'd1;
            end
          end
          RUN: begin
            state_s[i] = RUN;
            wcnt_s[i]  = 4'd0;
          end
          IDLE: begin
            state_s[i] = IDLE;
            wcnt_s[i]  = 4'd0;
          end
          default: begin
            state_s[i] = IDLE;
            wcnt_s[i]  = 4'd0;
          end
        endcase
      end
      run_mask_s[i] = (state_s[i] == RUN);
    end
  end

  // State, counters and registered issue outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NHARTS; i++) begin
        state_r[i] <= (i == 0) ? RUN : IDLE;
        cool_r[i]  <= 3'd0;
        wcnt_r[i]  <= 4'd0;
      end
      last_r        <= LAST_RST;
      issue_valid_r <= 1'b0;
      issue_tid_r   <= {TIDW{1'b0}};
      run_mask_r    <= NHARTS'(1);
    end else begin
      for (int i = 0; i < NHARTS; i++) begin
        state_r[i] <= state_s[i];
        cool_r[i]  <= cool_s[i];
        wcnt_r[i]  <= wcnt_s[i];
      end
      run_mask_r <= run_mask_s;
      if (found_s && !bus.pipe_stall) begin
        issue_valid_r <= 1'b1;
        issue_tid_r   <= grant_s;
        last_r        <= grant_s;
      end else begin
        issue_valid_r <= 1'b0;
      end
    end
  end

  assign bus.issue_valid = issue_valid_r;
  assign bus.issue_tid   = issue_tid_r;
  assign bus.run_mask    = run_mask_r;
endmodule

// File: doc/rv_hart_sched.md
# rv_hart_sched

Hardware-thread (hart) scheduler for the barrel-threaded RISC-V core. Each cycle it picks one runnable hart in round-robin order and issues its thread ID to fetch/decode, which then drives the shared decode and immediate-generation datapath for that hart. It enforces a minimum re-issue gap per hart, because the pipeline has no bypass network. It also tracks each hart's run/idle/wait state from commands sent by the execute stage.

## Interface
- NHARTS, 4: number of hardware threads (power of two, 2..8)
- TIDW, 2: thread-ID width, log2(NHARTS)
- MIN_GAP, 4: minimum cycles between two issues of the same hart (1..8)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- pipe_stall  in  1  pipeline stalled; hold issue
- start_valid  in  1  move hart start_tid to RUN
- start_tid  in  TIDW  target of start
- halt_valid  in  1  move hart halt_tid to IDLE
- halt_tid  in  TIDW  target of halt
- wait_valid  in  1  move hart wait_tid to WAIT for wait_cycles cycles
- wait_tid  in  TIDW  target of wait
- wait_cycles  in  4  wait length; 0 is treated as 1
- issue_valid  out  1  registered; issue_tid is valid this cycle
- issue_tid  out  TIDW  registered; hart issued this cycle
- run_mask  out  NHARTS  registered; bit i = hart i in RUN

## Operation
- Per-hart state: IDLE, RUN or WAIT.
- Per-hart counters:
  - 3-bit cooldown counter.
  - 4-bit wait counter.
- Global counter: last-issued pointer `last`.
- A hart is eligible when it is in RUN and its cooldown is 0.
- Grant: the first eligible hart in circular order last+1, last+2, …, last (wraps modulo NHARTS).
  - If at least one hart is eligible and pipe_stall=0: next issue_valid=1, issue_tid=grant, `last`<=grant, and the grant's cooldown is loaded with MIN_GAP-1.
  - Otherwise: next issue_valid=0; issue_tid holds its last value.
- Cooldowns decrement toward 0 each cycle pipe_stall=0. They are frozen while pipe_stall=1, because in-flight instructions do not advance.
- WAIT behaviour:
  - The wait counter is loaded with max(wait_cycles,1) and decrements every cycle, regardless of pipe_stall.
  - When the counter reaches 1 at an edge, the hart goes to RUN.
- State transitions:
  - IDLE→RUN on start.
  - RUN→IDLE on halt.
  - RUN→WAIT on wait.
  - WAIT→RUN on counter expiry, or on start (the counter is cleared).
  - WAIT→IDLE on halt.
  - Start to a hart already in RUN: no effect. Wait to an IDLE hart: ignored.
- Several commands to the same tid in one cycle: priority halt > wait > start. Commands to different tids all take effect.
- A command does not retract an issue already registered. It changes eligibility from the next decision onward.
- MIN_GAP=1 means no gap: a single running hart issues every cycle.

## Timing
- Decision is combinational on the current state; outputs are registered.
- A command sampled at edge k affects the issue produced at edge k+1, visible in the following cycle.
- run_mask reflects state after the same edge as the state change.
- pipe_stall high in cycle t: issue_valid=0 in cycle t+1; `last` and cooldowns are unchanged.
- Reset (any cycle, including mid-wait or mid-stall), state after the reset edge:
  - hart 0 RUN; all other harts IDLE.
  - all cooldowns and wait counters 0.
  - `last`=NHARTS-1.
  - issue_valid=0, issue_tid=0, run_mask=1.
- First issue after reset: hart 0, issue_valid=1 in the cycle after the first edge with rst=0.

## Test plan
- Boot: release rst with no commands (NHARTS=4, MIN_GAP=4). Required: issue_tid=0 once every 4 cycles, issue_valid=0 in between, run_mask=0001.
- Full rotation: start harts 1, 2, 3 in one cycle. Required: issue_tid sequence 0,1,2,3,0,1,… with issue_valid=1 every cycle, run_mask=1111.
- Gap enforcement: run harts 0 and 2 only. Required: issue 0,2,–,–,0,2,–,–; no hart repeats within 4 cycles.
- Wait:
  - With all 4 running, wait_valid tid=1 wait_cycles=3. Required: hart 1 absent from issues for 3 cycles, then rejoins the rotation; run_mask bit1 clears, then sets.
  - wait_cycles=0 behaves as 1.
- Priority and halt:
  - halt and start to tid 2 in the same cycle. Required: hart 2 IDLE.
  - halt the only running hart. Required: issue_valid stays 0 until a start arrives.
- Stall and reset:
  - pipe_stall high for 5 cycles mid-rotation. Required: no issues; rotation resumes at the next hart in order, with cooldowns unchanged across the stall.
  - Assert rst during a WAIT. Required: reset values above, then the boot behaviour.
